mdio_arbiter: RTL and testbench

MDIO_ARBITER -- requirements
Module: mdio_arbiter

---
 rtl/mdio_arbiter.sv | 141 ++++++++++++++
 tb/tb_mdio_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_arbiter.sv
// Two-requester round-robin arbiter in front of a single MDIO master.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// A WAIT phase that lasts TIMEOUT_CYC cycles without op_done is aborted with err set.
module mdio_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // requester a
    input  logic        req_a,
    input  logic        we_a,
    input  logic [4:0]  addr_a,
    input  logic [15:0] wdata_a,
    output logic        gnt_a,
    output logic        done_a,
    output logic [15:0] rdata_a,
    output logic        err_a,
    // requester b
    input  logic        req_b,
    input  logic        we_b,
    input  logic [4:0]  addr_b,
    input  logic [15:0] wdata_b,
    output logic        gnt_b,
    output logic        done_b,
    output logic [15:0] rdata_b,
    output logic        err_b,
    // downstream MDIO master
    output logic [15:0] ctrl_data,
    output logic [4:0]  reg_addr,
    output logic        write_request,
    output logic        read_request,
    input  logic [15:0] read_data,
    input  logic        op_done,
    output logic        busy
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state;
    logic            owner_b;  // 1: b owns the transaction in flight
    logic            last_b;   // 1: b was granted last
    logic            we_r;
    logic [CntW-1:0] cnt;

    logic            win_b;
    logic            win_we;
    logic [4:0]      win_addr;
    logic [15:0]     win_wdata;

    // b wins only if a is not asking or a was served last
    assign win_b     = req_b && (!req_a || !last_b);
    assign win_we    = win_b ? we_b : we_a;
    assign win_addr  = win_b ? addr_b : addr_a;
    assign win_wdata = win_b ? wdata_b : wdata_a;

    assign busy = (state != StIdle);

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= StIdle;
            owner_b       <= 1'b0;
            last_b        <= 1'b1;
            we_r          <= 1'b0;
            cnt           <= '0;
            gnt_a         <= 1'b0;
            gnt_b         <= 1'b0;
            done_a        <= 1'b0;
            done_b        <= 1'b0;
            rdata_a       <= 16'h0000;
            rdata_b       <= 16'h0000;
            err_a         <= 1'b0;
            err_b         <= 1'b0;
            ctrl_data     <= 16'h0000;
            reg_addr      <= 5'h00;
            write_request <= 1'b0;
            read_request  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_a || req_b) begin
                        state         <= StIssue;
                        owner_b       <= win_b;
                        gnt_a         <= !win_b;
                        gnt_b         <= win_b;
                        we_r          <= win_we;
                        reg_addr      <= win_addr;
                        ctrl_data     <= win_wdata;
                        write_request <= win_we;
                        read_request  <= !win_we;
                    end
                end
                StIssue: begin
                    write_request <= 1'b0;
                    read_request  <= 1'b0;
                    cnt           <= '0;
                    state         <= StWait;
                end
                StWait: begin
                    // op_done takes precedence over a simultaneous timeout
                    if (op_done) begin
                        state   <= StDone;
                        done_a  <= !owner_b;
                        done_b  <= owner_b;
                        rdata_a <= (!owner_b && !we_r) ? read_data : 16'h0000;
                        rdata_b <= (owner_b && !we_r) ? read_data : 16'h0000;
                        err_a   <= 1'b0;
                        err_b   <= 1'b0;
                    end else if (cnt == CntLast) begin
                        state   <= StDone;
                        done_a  <= !owner_b;
                        done_b  <= owner_b;
                        rdata_a <= 16'h0000;
                        rdata_b <= 16'h0000;
                        err_a   <= !owner_b;
                        err_b   <= owner_b;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    done_a  <= 1'b0;
                    done_b  <= 1'b0;
                    rdata_a <= 16'h0000;
                    rdata_b <= 16'h0000;
                    err_a   <= 1'b0;
                    err_b   <= 1'b0;
                    gnt_a   <= 1'b0;
                    gnt_b   <= 1'b0;
                    last_b  <= owner_b;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter: vector table of single transactions plus
// hand-written contention, stale op_done and mid-transaction reset sequences.
module tb_mdio_arbiter;

    localparam int unsigned T = 4096;

    logic        clk;
    logic        rst_ni;
    logic        req_a, we_a, req_b, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        gnt_a, done_a, err_a, gnt_b, done_b, err_b;
    logic [15:0] rdata_a, rdata_b;
    logic [15:0] ctrl_data;
    logic [4:0]  reg_addr;
    logic        write_request, read_request;
    logic [15:0] read_data;
    logic        op_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mdio_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_a         (req_a),
        .we_a          (we_a),
        .addr_a        (addr_a),
        .wdata_a       (wdata_a),
        .gnt_a         (gnt_a),
        .done_a        (done_a),
        .rdata_a       (rdata_a),
        .err_a         (err_a),
        .req_b         (req_b),
        .we_b          (we_b),
        .addr_b        (addr_b),
        .wdata_b       (wdata_b),
        .gnt_b         (gnt_b),
        .done_b        (done_b),
        .rdata_b       (rdata_b),
        .err_b         (err_b),
        .ctrl_data     (ctrl_data),
        .reg_addr      (reg_addr),
        .write_request (write_request),
        .read_request  (read_request),
        .read_data     (read_data),
        .op_done       (op_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // sel: 0=a 1=b; dly: WAIT cycle index where op_done is driven, -1 = never;
    // stale: op_done also driven during ISSUE; lat: negedges from ISSUE to DONE
    typedef struct {
        bit          sel;
        bit          we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        int          dly;
        logic [15:0] rd;
        bit          stale;
        bit          exp_wr;
        logic [15:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Structural invariants every cycle out of reset
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("invariants",
                {28'd0,
                 gnt_a & gnt_b,
                 write_request & read_request,
                 (!done_a && (rdata_a != 16'h0 || err_a)) || (!done_b && (rdata_b != 16'h0 || err_b)),
                 busy != (gnt_a | gnt_b)},
                32'd0);
        end
    end

    task automatic drop_req(input bit sel);
        if (!sel) req_a = 1'b0;
        else      req_b = 1'b0;
    endtask

    // Runs one transaction for the selected requester; called at a negedge.
    task automatic do_txn(input vec_t v);
        int lat;
        bit seen;
        if (!v.sel) begin
            req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
        end else begin
            req_b = 1'b1; we_b = v.we; addr_b = v.addr; wdata_b = v.wdata;
        end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (write_request || read_request) seen = 1'b1;
        end
        chk("issue_seen", 32'(seen), 32'd1);
        if (!seen) begin
            drop_req(v.sel);
            return;
        end
        chk("gnt_a", 32'(gnt_a), 32'(!v.sel));
        chk("gnt_b", 32'(gnt_b), 32'(v.sel));
        chk("reg_addr", 32'(reg_addr), 32'(v.addr));
        chk("ctrl_data", 32'(ctrl_data), 32'(v.wdata));
        chk("write_request", 32'(write_request), 32'(v.exp_wr));
        chk("read_request", 32'(read_request), 32'(!v.exp_wr));
        // inputs change after grant; the transaction must not notice
        if (!v.sel) begin
            we_a = ~v.we; addr_a = ~v.addr; wdata_a = ~v.wdata;
        end else begin
            we_b = ~v.we; addr_b = ~v.addr; wdata_b = ~v.wdata;
        end
        op_done   = v.stale;
        read_data = 16'hDEAD;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= int'(T) + 8 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) chk("req_pulse_len", {30'd0, write_request, read_request}, 32'd0);
            if (done_a || done_b) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                op_done   = (v.dly >= 0) && (i == v.dly + 1);
                read_data = op_done ? v.rd : ~v.rd;
            end
        end
        op_done = 1'b0;
        chk("done_latency", 32'(lat), 32'(v.exp_lat));
        if (seen) begin
            chk("done_a", 32'(done_a), 32'(!v.sel));
            chk("done_b", 32'(done_b), 32'(v.sel));
            chk("rdata", 32'(v.sel ? rdata_b : rdata_a), 32'(v.exp_rdata));
            chk("err", 32'(v.sel ? err_b : err_a), 32'(v.exp_err));
            chk("gnt_in_done", 32'(v.sel ? gnt_b : gnt_a), 32'd1);
        end
        drop_req(v.sel);
        @(negedge clk);
        chk("idle_after_done", {27'd0, busy, gnt_a, gnt_b, done_a, done_b}, 32'd0);
    endtask

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv;
        bit   seen;
        bit   exp_b;
        int   na;
        int   nb;

        vecs[0] = '{1'b0, 1'b0, 5'h01, 16'h0000, 1599, 16'h796D, 1'b0, 1'b0, 16'h796D, 1'b0, 1601};
        vecs[1] = '{1'b1, 1'b1, 5'h00, 16'h8000, 3,    16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 5};
        vecs[2] = '{1'b0, 1'b0, 5'h1F, 16'hABCD, -1,   16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 4097};
        vecs[3] = '{1'b1, 1'b0, 5'h0A, 16'h0000, 0,    16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0, 2};
        vecs[4] = '{1'b0, 1'b1, 5'h11, 16'h5A5A, 4095, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0, 4097};
        vecs[5] = '{1'b1, 1'b0, 5'h03, 16'h0000, 4095, 16'hC0DE, 1'b0, 1'b0, 16'hC0DE, 1'b0, 4097};

        rst_ni = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 5'h00; wdata_a = 16'h0000;
        req_b = 1'b0; we_b = 1'b0; addr_b = 5'h00; wdata_b = 16'h0000;
        read_data = 16'h0000; op_done = 1'b0;
        #50;
        chk("reset_ctrl", {10'd0, busy, gnt_a, gnt_b, done_a, done_b, err_a, err_b,
                           write_request, read_request, reg_addr, 2'd0}, 32'd0);
        chk("reset_data", {rdata_a | rdata_b, ctrl_data}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int k = 0; k < 6; k++) do_txn(vecs[k]);

        // Contention: both hold requests for three transactions each
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'h02;
        req_b = 1'b1; we_b = 1'b0; addr_b = 5'h04;
        na = 0;
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            exp_b = k[0];
            seen  = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk);
                op_done = 1'b0;
                if (read_request || write_request) seen = 1'b1;
            end
            chk("cont_issue_seen", 32'(seen), 32'd1);
            chk("cont_gnt_a", 32'(gnt_a), 32'(!exp_b));
            chk("cont_gnt_b", 32'(gnt_b), 32'(exp_b));
            chk("cont_reg_addr", 32'(reg_addr), exp_b ? 32'h4 : 32'h2);
            @(negedge clk);
            op_done   = 1'b1;
            read_data = 16'h1000 + 16'(k);
            @(negedge clk);
            // op_done stays high through DONE and must be ignored there
            chk("cont_done_a", 32'(done_a), 32'(!exp_b));
            chk("cont_done_b", 32'(done_b), 32'(exp_b));
            chk("cont_rdata", 32'(exp_b ? rdata_b : rdata_a), 32'h1000 + 32'(k));
            if (done_a) na++;
            if (done_b) nb++;
            if (na == 3) req_a = 1'b0;
            if (nb == 3) req_b = 1'b0;
        end
        @(negedge clk);
        op_done = 1'b0;
        @(negedge clk);
        chk("cont_idle", {30'd0, busy, done_a | done_b}, 32'd0);

        // Stale op_done in IDLE
        op_done   = 1'b1;
        read_data = 16'hFFFF;
        @(negedge clk);
        op_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_idle", {28'd0, busy, gnt_a | gnt_b, done_a, done_b}, 32'd0);
        end

        // Serve a so the last-grant pointer points at a before reset
        tv = '{1'b0, 1'b1, 5'h05, 16'h0F0F, 0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 2};
        do_txn(tv);

        // Reset in the middle of a b read
        req_b = 1'b1; we_b = 1'b0; addr_b = 5'h07;
        seen  = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (read_request) seen = 1'b1;
        end
        chk("rst_issue_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #5;
        rst_ni = 1'b0;
        req_b  = 1'b0;
        #1;
        chk("rst_async_ctrl", {10'd0, busy, gnt_a, gnt_b, done_a, done_b, err_a, err_b,
                               write_request, read_request, reg_addr, 2'd0}, 32'd0);
        chk("rst_async_data", {rdata_a | rdata_b, ctrl_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_done", {30'd0, done_a, done_b}, 32'd0);
        rst_ni = 1'b1;

        // Both request right after release: a must win as pointer was reset to b
        req_b = 1'b1; we_b = 1'b0; addr_b = 5'h08;
        tv = '{1'b0, 1'b0, 5'h0C, 16'h0000, 1, 16'h2222, 1'b0, 1'b0, 16'h2222, 1'b0, 3};
        do_txn(tv);
        tv = '{1'b1, 1'b0, 5'h08, 16'h0000, 2, 16'h3333, 1'b0, 1'b0, 16'h3333, 1'b0, 4};
        do_txn(tv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
